reg_bank_arbiter: RTL

Round-robin write arbiter that shares one WIDTH-bit registered output stage (a bank of D flip-flops, one per bit) among NREQ requesters. Each requester presents a word with a request/acknowledge handshake. The arbiter captures the winning word into the output register and presents it downstream with a valid/ready handshake. It sits between several producer blocks and a single consumer of a 5-bit registered bus in the ice40 designs.

---
 rtl/reg_bank_arbiter.sv | 121 ++++++++++++
 1 files changed

// File: rtl/reg_bank_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_bank_arbiter
// Brief    : Round-robin write arbiter. It shares one registered WIDTH-bit
//            output stage among NREQ requesters. Requesters use a REQ/ACK
//            handshake. The output uses a VALID/READY handshake.
//            Optional feature macro: REG_ARB_LOCK_EN. When defined, it lets
//            the current grant holder keep the grant while it asserts LOCK.
// Revision : 1.0 - initial release
// ============================================================================
module reg_bank_arbiter #(
  parameter int WIDTH = 5,
  parameter int NREQ  = 4   // legal range 2..4
) (
  input  logic                  CLK,
  input  logic                  RESETN,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*WIDTH-1:0] I,
  input  logic [NREQ-1:0]       LOCK,
  output logic [NREQ-1:0]       ACK,
  output logic [WIDTH-1:0]      O,
  output logic                  VALID,
  input  logic                  READY,
  output logic [1:0]            GNT_ID
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;
  localparam logic [1:0] C_LAST   = 2'(NREQ - 1);

  logic [0:0]       r_state;
  logic [1:0]       r_ptr;
  logic [WIDTH-1:0] r_data;
  logic [1:0]       r_gnt_id;

  logic             w_accept;
  logic             w_found;
  logic             w_locked;
  logic [1:0]       w_win;
  logic [1:0]       w_ptr_next;
  logic [WIDTH-1:0] w_data;

  // Accept whenever someone requests and the holding stage is free or draining.
  // Reset gates the accept so that ACK drops as soon as reset is asserted.
  assign w_accept = RESETN && (|REQ) && ((r_state == ST_EMPTY) || READY);

  // Winner select: scan priority positions ptr, ptr+1, ... and take the first requester.
  // A lock held by the current grant owner overrides the scan.
  always_comb begin
    w_found  = 1'b0;
    w_locked = 1'b0;
    w_win    = 2'd0;
    for (int i = 0; i < NREQ; i++) begin
      for (int k = 0; k < NREQ; k++) begin
        if (!w_found && REQ[k] && (((int'(r_ptr) + i) % NREQ) == k)) begin
          w_found = 1'b1;
          w_win   = 2'(k);
        end
      end
    end
`ifdef REG_ARB_LOCK_EN
    for (int k = 0; k < NREQ; k++) begin
      if ((int'(r_gnt_id) == k) && LOCK[k] && REQ[k]) begin
        w_locked = 1'b1;
        w_win    = 2'(k);
      end
    end
`endif
  end

`ifndef REG_ARB_LOCK_EN
  // LOCK is part of the port list for pin compatibility only.
  logic w_unused_lock;
  assign w_unused_lock = ^LOCK;
`endif

  assign w_ptr_next = (w_win == C_LAST) ? 2'd0 : w_win + 2'd1;

  // Data mux: pick the winning requester's word. This path feeds only the output register.
  always_comb begin
    w_data = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_win == 2'(k)) begin
        w_data = I[k*WIDTH +: WIDTH];
      end
    end
  end

  // One-hot acknowledge for the winner in the accepting cycle.
  generate
    for (genvar k = 0; k < NREQ; k++) begin : g_ack
      assign ACK[k] = w_accept && (w_win == 2'(k));
    end
  endgenerate

  // Holding stage. It loads on accept and empties when downstream takes the word.
  // Locked grants leave the round-robin pointer untouched.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      r_state  <= ST_EMPTY;
      r_ptr    <= 2'd0;
      r_data   <= '0;
      r_gnt_id <= 2'd0;
    end else if (w_accept) begin
      r_state  <= ST_FULL;
      r_data   <= w_data;
      r_gnt_id <= w_win;
      if (!w_locked) begin
        r_ptr <= w_ptr_next;
      end
    end else if ((r_state == ST_FULL) && READY) begin
      r_state <= ST_EMPTY;
    end
  end

  assign O      = r_data;
  assign VALID  = (r_state == ST_FULL);
  assign GNT_ID = r_gnt_id;

endmodule
`default_nettype wire
